// File: rtl/demux_rr_dispatcher.sv
// rtl/demux_rr_dispatcher.sv - round-robin 1-to-8 word dispatcher with registered one-hot valid (optional DEMUX_RR_WDOG_EN stall watchdog)
module demux_rr_dispatcher #(
    parameter int DW       = 8,
    parameter int WDOG_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [7:0]    mask,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic [7:0]    ch_valid,
    output logic [DW-1:0] ch_data,
    input  logic [7:0]    ch_ready,
    output logic [2:0]    ch_sel,
    output logic          busy,
    output logic [15:0]   disp_cnt,
    output logic          wdog_drop
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state, state_nx;
    logic [2:0] ptr;
    logic [2:0] grant;
    logic       out_fire;
    logic       s_fire;
    logic       drop;

    assign busy     = (state == SEND);
    assign out_fire = busy & ch_ready[ch_sel];
    assign s_ready  = en & (|mask) & (~busy | out_fire) & ~drop;
    assign s_fire   = s_valid & s_ready;
    assign ch_valid = busy ? (8'd1 << ch_sel) : 8'd0;

    // Grant: first eligible channel after ptr, wrapping; ptr itself has lowest priority
    always_comb begin
        logic [2:0] idx;
        grant = ptr;
        idx   = ptr;
        for (int i = 8; i >= 1; i--) begin
            idx = ptr + 3'(i);
            if (mask[idx]) grant = idx;
        end
    end

`ifdef DEMUX_RR_WDOG_EN
    localparam int CW = $clog2(WDOG_CYC + 1);

    logic [CW-1:0] wcnt;

    // The last allowed stall cycle is the one where the count already equals WDOG_CYC-1
    assign drop = busy & ~ch_ready[ch_sel] & (wcnt == CW'(WDOG_CYC - 1));

    // Consecutive stall counter; restarts whenever a word is loaded or leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            wdog_drop <= 1'b0;
        end else begin
            wdog_drop <= drop;
            if (s_fire || out_fire || drop)
                wcnt <= '0;
            else if (busy)
                wcnt <= wcnt + 1'b1;
        end
    end
`else
    assign drop      = 1'b0;
    assign wdog_drop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: load on accept, leave SEND on completion without reload or on drop
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (s_fire) state_nx = SEND;
            SEND: begin
                if (out_fire)  state_nx = s_fire ? SEND : IDLE;
                else if (drop) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output word register, grant pointer and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data  <= '0;
            ch_sel   <= 3'd0;
            ptr      <= 3'd7;
            disp_cnt <= 16'd0;
        end else begin
            if (s_fire) begin
                ch_data <= s_data;
                ch_sel  <= grant;
                ptr     <= grant;
            end
            if (out_fire) disp_cnt <= disp_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb/tb_demux_rr_dispatcher.sv - scoreboard bench for demux_rr_dispatcher
module tb_demux_rr_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  mask;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [7:0]  ch_valid;
    logic [7:0]  ch_data;
    logic [7:0]  ch_ready;
    logic [2:0]  ch_sel;
    logic        busy;
    logic [15:0] disp_cnt;
    logic        wdog_drop;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    demux_rr_dispatcher #(.DW(8), .WDOG_CYC(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mask     (mask),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .ch_sel   (ch_sel),
        .busy     (busy),
        .disp_cnt (disp_cnt),
        .wdog_drop(wdog_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output transfer is matched against the oldest expected word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ch_valid != 8'd0 && (ch_valid & ch_ready) != 8'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got ch_valid=0x%0h data=0x%0h expected none", ch_valid, ch_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_valid", {24'd0, ch_valid}, {24'd0, 8'd1 << e.ch});
                chk("out_data",  {24'd0, ch_data},  {24'd0, e.data});
            end
        end
    end

    // Offer one word; push its expected channel when accepted; waits reports cycles spent stalled
    task automatic send(input logic [7:0] d, input logic [2:0] ch, input bit keep, output int waits);
        bit ok;
        s_valid = 1'b1;
        s_data  = d;
        waits   = 0;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            else         waits++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got s_ready=0 expected 1 within 50 cycles");
        end else begin
            exp_q.push_back('{ch: ch, data: d});
        end
        @(posedge clk); #1;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [2:0] t1_ch [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [2:0] t2_ch [4]  = '{3'd2, 3'd5, 3'd7, 3'd2};

    initial begin
        int w;
        int wsum;
        bit seen;
        rst_n    = 1'b0;
        en       = 1'b1;
        mask     = 8'hFF;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        ch_ready = 8'hFF;
        #1;
        chk("reset_ch_valid", {24'd0, ch_valid}, 32'd0);
        chk("reset_busy",     {31'd0, busy},     32'd0);
        cycles(2);
        chk("reset_disp_cnt", {16'd0, disp_cnt}, 32'd0);
        chk("reset_ch_sel",   {29'd0, ch_sel},   32'd0);
        chk("reset_ch_data",  {24'd0, ch_data},  32'd0);
        chk("reset_wdog",     {31'd0, wdog_drop}, 32'd0);
        rst_n = 1'b1;
        cycles(1);

        // 1: ten back-to-back words across all channels
        wsum = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(i), t1_ch[i], i != 9, w);
            wsum += w;
        end
        chk("t1_stall_cycles", wsum, 32'd0);
        cycles(2);
        chk("t1_disp_cnt", {16'd0, disp_cnt}, 32'd10);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: sparse mask rotation
        mask = 8'b1010_0100;
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), t2_ch[i], i != 3, w);
        cycles(2);
        chk("t2_disp_cnt", {16'd0, disp_cnt}, 32'd14);

        // 3: backpressure on ch3 holds the word
        mask     = 8'h08;
        ch_ready = 8'hF7;
        send(8'hA5, 3'd3, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", {24'd0, ch_valid}, 32'h08);
            chk("t3_hold_data",  {24'd0, ch_data},  32'hA5);
            chk("t3_s_ready",    {31'd0, s_ready},  32'd0);
        end
        @(posedge clk); #1;
        ch_ready = 8'hFF;
        cycles(1);
        chk("t3_released_busy", {31'd0, busy}, 32'd0);
        chk("t3_disp_cnt", {16'd0, disp_cnt}, 32'd15);

        // 4: empty mask blocks input; single channel takes the next word
        mask    = 8'h00;
        s_valid = 1'b1;
        s_data  = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_s_ready", {31'd0, s_ready}, 32'd0);
            chk("t4_ch_valid", {24'd0, ch_valid}, 32'd0);
        end
        @(posedge clk); #1;
        mask = 8'h10;
        send(8'h44, 3'd4, 1'b0, w);
        cycles(2);
        chk("t4_disp_cnt", {16'd0, disp_cnt}, 32'd16);

        // 5: asynchronous reset while a word is pending
        mask     = 8'hFF;
        ch_ready = 8'h00;
        send(8'h55, 3'd5, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ch_valid", {24'd0, ch_valid}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        cycles(1);
        rst_n    = 1'b1;
        ch_ready = 8'hFF;
        cycles(1);
        chk("t5_disp_cnt_zero", {16'd0, disp_cnt}, 32'd0);
        send(8'h66, 3'd0, 1'b0, w);
        cycles(2);
        chk("t5_disp_cnt_one", {16'd0, disp_cnt}, 32'd1);

        // 6: indefinite stall (watchdog behaviour depends on build)
        ch_ready = 8'h00;
`ifdef DEMUX_RR_WDOG_EN
        send(8'h77, 3'd1, 1'b0, w);
        void'(exp_q.pop_back());
        seen = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i < 17) chk("t6_no_early_drop", {31'd0, wdog_drop}, 32'd0);
            else begin
                chk("t6_drop_pulse", {31'd0, wdog_drop}, 32'd1);
                chk("t6_drop_busy",  {31'd0, busy},      32'd0);
            end
        end
        @(negedge clk);
        chk("t6_pulse_one_cycle", {31'd0, wdog_drop}, 32'd0);
        chk("t6_disp_cnt", {16'd0, disp_cnt}, 32'd1);
        ch_ready = 8'hFF;
        cycles(1);
        send(8'h78, 3'd2, 1'b0, w);
        cycles(2);
        chk("t6_after_drop_cnt", {16'd0, disp_cnt}, 32'd2);
`else
        send(8'h77, 3'd1, 1'b0, w);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wdog_drop || !busy) seen = 1'b1;
        end
        chk("t6_no_drop_100", {31'd0, seen}, 32'd0);
        chk("t6_still_valid", {24'd0, ch_valid}, 32'h02);
        @(posedge clk); #1;
        ch_ready = 8'hFF;
        cycles(2);
        chk("t6_disp_cnt", {16'd0, disp_cnt}, 32'd2);
`endif

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
